// File: rtl/instruction_fetch_unit_if.sv
// Loader, control and IF/ID-latch signals of the instruction fetch unit.
// The master side drives the fetch unit's inputs; the slave side is the fetch unit.
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 9
);
    logic                  i_load_start;
    logic                  i_load_valid;
    logic [7:0]            i_load_byte;
    logic                  i_run;
    logic                  i_stall;
    logic                  i_jump;
    logic [31:0]           i_jump_address;
    logic [31:0]           o_instruction;
    logic                  o_valid;
    logic [31:0]           o_pc;
    logic [31:0]           o_pc_next;
    logic [ADDR_WIDTH:0]   o_load_count;
    logic [1:0]            o_state;
    logic                  o_halted;

    modport master (
        output i_load_start, i_load_valid, i_load_byte, i_run, i_stall, i_jump, i_jump_address,
        input  o_instruction, o_valid, o_pc, o_pc_next, o_load_count, o_state, o_halted
    );

    modport slave (
        input  i_load_start, i_load_valid, i_load_byte, i_run, i_stall, i_jump, i_jump_address,
        output o_instruction, o_valid, o_pc, o_pc_next, o_load_count, o_state, o_halted
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: serially loaded byte memory, PC sequencing, halt detection,
// jump flush with NOP injection and the IF/ID instruction latch.
module instruction_fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input logic                     i_clk,
    input logic                     i_reset_n,
    instruction_fetch_unit_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pc_n;
    logic [ADDR_WIDTH-1:0] inst_pc, inst_pc_n;
    logic [31:0]           inst, inst_n;
    logic                  valid, valid_n;
    logic [ADDR_WIDTH:0]   load_count, load_count_n;
    logic                  mem_we;
    logic [7:0]            mem [DEPTH];
    logic [7:0]            fetch_byte [4];
    logic [31:0]           fetch_word;
    logic                  unused_jump_bits;

    // Byte addresses PC..PC+3 wrap within the memory.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fetch_byte[i] = mem[pc + ADDR_WIDTH'(i)];
        end
        fetch_word = BIG_ENDIAN ? {fetch_byte[0], fetch_byte[1], fetch_byte[2], fetch_byte[3]}
                                : {fetch_byte[3], fetch_byte[2], fetch_byte[1], fetch_byte[0]};
    end

    // NOTE: the memory array has no reset branch; a loaded program survives i_reset_n.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[load_count[ADDR_WIDTH-1:0]] <= bus.i_load_byte;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= ST_IDLE;
            pc         <= '0;
            inst_pc    <= '0;
            inst       <= NOP_WORD;
            valid      <= 1'b0;
            load_count <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            inst_pc    <= inst_pc_n;
            inst       <= inst_n;
            valid      <= valid_n;
            load_count <= load_count_n;
        end
    end

    always_comb begin
        // NOTE: every next-value signal defaults to "hold" first so no path infers a latch.
        state_n      = state;
        pc_n         = pc;
        inst_pc_n    = inst_pc;
        inst_n       = inst;
        valid_n      = valid;
        load_count_n = load_count;
        mem_we       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.i_load_start) begin
                    state_n      = ST_LOAD;
                    load_count_n = '0;
                end else if (bus.i_run) begin
                    state_n = ST_RUN;
                    pc_n    = '0;
                    inst_n  = NOP_WORD;
                    valid_n = 1'b0;
                end
            end
            ST_LOAD: begin
                if (bus.i_load_start) begin
                    load_count_n = '0;
                end else begin
                    // Count saturates at DEPTH; the pointer never wraps onto byte 0.
                    if (bus.i_load_valid && !load_count[ADDR_WIDTH]) begin
                        mem_we       = 1'b1;
                        load_count_n = load_count + (ADDR_WIDTH + 1)'(1);
                    end
                    if (bus.i_run) begin
                        state_n = ST_RUN;
                        pc_n    = '0;
                        inst_n  = NOP_WORD;
                        valid_n = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (bus.i_jump) begin
                    pc_n    = {bus.i_jump_address[ADDR_WIDTH-1:2], 2'b00};
                    inst_n  = NOP_WORD;
                    valid_n = 1'b0;
                end else if (!bus.i_stall) begin
                    inst_n    = fetch_word;
                    inst_pc_n = pc;
                    valid_n   = 1'b1;
                    if (fetch_word == HALT_WORD) begin
                        state_n = ST_HALTED;
                    end else begin
                        pc_n = pc + ADDR_WIDTH'(4);
                    end
                end
            end
            ST_HALTED: begin
                inst_n  = NOP_WORD;
                valid_n = 1'b0;
                if (bus.i_load_start) begin
                    state_n      = ST_LOAD;
                    pc_n         = '0;
                    load_count_n = '0;
                end else if (bus.i_run) begin
                    state_n = ST_RUN;
                    pc_n    = '0;
                end
            end
            default: ;
        endcase
    end

    assign unused_jump_bits  = ^{bus.i_jump_address[31:ADDR_WIDTH], bus.i_jump_address[1:0]};

    assign bus.o_instruction = inst;
    assign bus.o_valid       = valid;
    assign bus.o_pc          = 32'(inst_pc);
    assign bus.o_pc_next     = 32'(pc);
    assign bus.o_load_count  = load_count;
    assign bus.o_state       = state;
    assign bus.o_halted      = (state == ST_HALTED);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Two fetch units (9-bit big-endian, 4-bit little-endian) share one stimulus stream;
// a behavioural model feeds per-unit scoreboards that a monitor drains.
module tb_instruction_fetch_unit;
    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic i_clk = 1'b0;
    logic i_reset_n = 1'b0;
    always #5 i_clk = ~i_clk;

    logic        ls = 1'b0, lv = 1'b0, run = 1'b0, stall = 1'b0, jump = 1'b0;
    logic [7:0]  lb = '0;
    logic [31:0] ja = '0;

    instruction_fetch_unit_if #(.ADDR_WIDTH(9)) bus_a ();
    instruction_fetch_unit_if #(.ADDR_WIDTH(4)) bus_b ();

    assign bus_a.i_load_start = ls;    assign bus_b.i_load_start = ls;
    assign bus_a.i_load_valid = lv;    assign bus_b.i_load_valid = lv;
    assign bus_a.i_load_byte = lb;     assign bus_b.i_load_byte = lb;
    assign bus_a.i_run = run;          assign bus_b.i_run = run;
    assign bus_a.i_stall = stall;      assign bus_b.i_stall = stall;
    assign bus_a.i_jump = jump;        assign bus_b.i_jump = jump;
    assign bus_a.i_jump_address = ja;  assign bus_b.i_jump_address = ja;

    instruction_fetch_unit #(.ADDR_WIDTH(9), .BIG_ENDIAN(1'b1)) dut_a (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(bus_a));
    instruction_fetch_unit #(.ADDR_WIDTH(4), .BIG_ENDIAN(1'b0)) dut_b (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(bus_b));

    int checks = 0;
    int errors = 0;

    // Reference model: 0 IDLE, 1 LOAD, 2 RUN, 3 HALTED.
    int          aw [2] = '{9, 4};
    bit          be [2] = '{1'b1, 1'b0};
    logic [7:0]  m_mem [2][512];
    int          m_st [2]  = '{0, 0};
    int          m_pc [2]  = '{0, 0};
    int          m_cnt [2] = '{0, 0};
    bit          m_v [2]   = '{1'b0, 1'b0};
    logic [31:0] m_instr [2] = '{NOP, NOP};
    int          m_ipc [2] = '{0, 0};
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_word(input int k, input int pc);
        int d = 1 << aw[k];
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = m_mem[k][(pc + i) % d];
        return be[k] ? {b[0], b[1], b[2], b[3]} : {b[3], b[2], b[1], b[0]};
    endfunction

    // Applies the current inputs to model k for the coming clock edge.
    function automatic void model_step(input int k);
        int d = 1 << aw[k];
        logic [31:0] w;
        if (!i_reset_n) begin
            m_st[k] = 0; m_pc[k] = 0; m_cnt[k] = 0; m_v[k] = 1'b0; m_instr[k] = NOP;
            return;
        end
        w = m_word(k, m_pc[k]);
        case (m_st[k])
            0: if (ls) begin
                   m_st[k] = 1; m_cnt[k] = 0;
               end else if (run) begin
                   m_st[k] = 2; m_pc[k] = 0; m_v[k] = 1'b0; m_instr[k] = NOP;
               end
            1: if (ls) begin
                   m_cnt[k] = 0;
               end else begin
                   if (lv && m_cnt[k] < d) begin
                       m_mem[k][m_cnt[k]] = lb;
                       m_cnt[k]++;
                   end
                   if (run) begin
                       m_st[k] = 2; m_pc[k] = 0; m_v[k] = 1'b0; m_instr[k] = NOP;
                   end
               end
            2: if (jump) begin
                   m_pc[k] = int'(ja % d) / 4 * 4;
                   m_v[k] = 1'b0; m_instr[k] = NOP;
               end else if (!stall) begin
                   m_instr[k] = w; m_ipc[k] = m_pc[k]; m_v[k] = 1'b1;
                   if (w == HALT) m_st[k] = 3;
                   else m_pc[k] = (m_pc[k] + 4) % d;
               end
            default: begin
                m_v[k] = 1'b0; m_instr[k] = NOP;
                if (ls) begin
                    m_st[k] = 1; m_pc[k] = 0; m_cnt[k] = 0;
                end else if (run) begin
                    m_st[k] = 2; m_pc[k] = 0;
                end
            end
        endcase
        if (m_v[k]) begin
            if (k == 0) q0.push_back({m_instr[k], 32'(m_ipc[k])});
            else        q1.push_back({m_instr[k], 32'(m_ipc[k])});
        end
    endfunction

    task automatic cycle(input logic r, input logic l_s, input logic l_v, input logic [7:0] l_b,
                         input logic r_n, input logic s, input logic j, input logic [31:0] j_a);
        @(negedge i_clk);
        i_reset_n = r; ls = l_s; lv = l_v; lb = l_b; run = r_n; stall = s; jump = j; ja = j_a;
        model_step(0);
        model_step(1);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic mon(input int k, input logic [31:0] instr, input logic v, input logic [31:0] pc,
                       input logic [31:0] pcn, input int cnt, input logic [1:0] st, input logic h);
        string n;
        logic [63:0] e;
        int qs;
        n = (k == 0) ? "a" : "b";
        qs = (k == 0) ? q0.size() : q1.size();
        check({n, "_pc_next"}, pcn, m_pc[k]);
        check({n, "_state"}, 32'(st), m_st[k]);
        check({n, "_load_count"}, cnt, m_cnt[k]);
        check({n, "_halted"}, 32'(h), 32'(m_st[k] == 3));
        check({n, "_valid"}, 32'(v), 32'(m_v[k]));
        if (v) begin
            if (qs == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_unexpected_fetch: got %h @%h, expected no valid word", n, instr, pc);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                check({n, "_instruction"}, instr, e[63:32]);
                check({n, "_pc"}, pc, e[31:0]);
            end
        end else begin
            check({n, "_nop_when_invalid"}, instr, NOP);
            if (qs != 0) begin
                if (k == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            mon(0, bus_a.o_instruction, bus_a.o_valid, bus_a.o_pc, bus_a.o_pc_next,
                int'(bus_a.o_load_count), bus_a.o_state, bus_a.o_halted);
            mon(1, bus_b.o_instruction, bus_b.o_valid, bus_b.o_pc, bus_b.o_pc_next,
                int'(bus_b.o_load_count), bus_b.o_state, bus_b.o_halted);
        end
    end

    logic [7:0] prog [12] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
                              8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] wb [20];

    initial begin
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
        idle();

        // Fill the whole memory so every later fetch reads defined bytes.
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 512; i++)
            cycle(1'b1, 1'b0, 1'b1, ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom), 1'b0, 1'b0, 1'b0, 32'h0);

        // Load and run the three-word program.
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b1, prog[i], 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0);
        idle();
        check("a_count_after_program", 32'(bus_a.o_load_count), 32'd12);
        repeat (4) idle();
        check("a_halted_after_program", 32'(bus_a.o_halted), 32'd1);
        check("a_pc_next_frozen", bus_a.o_pc_next, 32'h8);

        // Stall three cycles while the latch holds the word at pc 4.
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0);
        idle();
        idle();
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0);
        idle();
        check("a_stall_instruction", bus_a.o_instruction, 32'h2);
        check("a_stall_pc", bus_a.o_pc, 32'h4);
        check("a_stall_pc_next", bus_a.o_pc_next, 32'h8);
        idle();

        // Jump wins over a simultaneous stall.
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0);
        idle();
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
        idle();
        check("a_jump_pc_next", bus_a.o_pc_next, 32'h100);
        check("a_jump_flush_valid", 32'(bus_a.o_valid), 32'd0);
        check("b_jump_pc_next", bus_b.o_pc_next, 32'h0);
        idle();
        check("a_jump_target_pc", bus_a.o_pc, 32'h100);
        check("a_jump_target_valid", 32'(bus_a.o_valid), 32'd1);

        // Asynchronous reset between edges, then re-run the retained program.
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check("a_async_state", 32'(bus_a.o_state), 32'd0);
        check("a_async_valid", 32'(bus_a.o_valid), 32'd0);
        check("a_async_instruction", bus_a.o_instruction, NOP);
        check("a_async_pc_next", bus_a.o_pc_next, 32'h0);
        check("b_async_load_count", 32'(bus_b.o_load_count), 32'd0);
        idle();
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0);
        idle();
        idle();
        check("a_rerun_instruction", bus_a.o_instruction, 32'h1);
        check("a_rerun_pc", bus_a.o_pc, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
        idle();

        // Overflowing load, PC wrap and little-endian assembly; load bytes during RUN are dropped.
        for (int i = 0; i < 20; i++) wb[i] = 8'($urandom_range(254));
        wb[0] = 8'h33; wb[1] = 8'h44; wb[14] = 8'h11; wb[15] = 8'h22;
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b1, wb[i], 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0);
        idle();
        check("b_overflow_count", 32'(bus_b.o_load_count), 32'd16);
        check("a_count_20", 32'(bus_a.o_load_count), 32'd20);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'd12);
        cycle(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 32'h0);
        check("b_wrap_pc12", bus_b.o_pc, 32'd12);
        check("b_le_high_half", 32'(bus_b.o_instruction[31:16]), 32'h2211);
        cycle(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 32'h0);
        check("b_wrap_pc0", bus_b.o_pc, 32'd0);
        check("b_le_low_half", 32'(bus_b.o_instruction[15:0]), 32'h4433);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
        idle();
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) idle();

        // Randomised mix of every control input.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(199) != 0),
                  ($urandom_range(99) < 2),
                  ($urandom_range(99) < 50),
                  ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom),
                  ($urandom_range(99) < 4),
                  ($urandom_range(99) < 20),
                  ($urandom_range(99) < 6),
                  $urandom);
        end
        repeat (3) idle();
        @(posedge i_clk);
        #2;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d words left, expected 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Parametrised second-generation fetch stage for the pipelined MIPS-style core.
- Owns a byte-addressed instruction memory that is loaded serially, one byte per transfer, from the debug/UART loader.
- Sequences the program counter and registers the fetched instruction into the IF/ID latch.
- Adds over the previous fetch stage: a control FSM (idle/load/run/halted), self-detection of the halt instruction, jump flush with NOP injection, and a valid flag.

Parameters:
ADDR_WIDTH, 9, byte-address width; memory depth 2^ADDR_WIDTH bytes; PC wraps modulo 2^ADDR_WIDTH
BIG_ENDIAN, 1, 1 = byte at PC is instruction[31:24]; 0 = byte at PC is instruction[7:0]
NOP_WORD, 32'h0000_0000, word injected into the latch on flush or halt
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_load_start  in  1  pulse; enter LOAD, clear load pointer
i_load_valid  in  1  i_load_byte is valid this cycle
i_load_byte  in  8  program byte
i_run  in  1  pulse; start execution from PC 0
i_stall  in  1  hold PC and latch (hazard unit)
i_jump  in  1  redirect PC (branch/jump resolved downstream)
i_jump_address  in  32  jump target; bits [1:0] ignored
o_instruction  out  32  IF/ID instruction latch
o_valid  out  1  o_instruction holds a real fetched instruction
o_pc  out  32  PC of the instruction in the latch
o_pc_next  out  32  current fetch PC
o_load_count  out  ADDR_WIDTH+1  bytes written since i_load_start
o_state  out  2  0 IDLE, 1 LOAD, 2 RUN, 3 HALTED
o_halted  out  1  state == HALTED

Behaviour:
Reset (async, i_reset_n = 0):
- state IDLE; fetch PC 0; o_instruction NOP_WORD; o_valid 0; o_pc 0; o_load_count 0.
- Memory contents are not cleared.

Memory:
- Async read of 4 consecutive bytes at fetch PC, byte addresses PC..PC+3, each modulo 2^ADDR_WIDTH.
- Assembly order per BIG_ENDIAN.
- Synchronous single-byte write.

Output mapping:
- o_pc_next = zero-extended fetch PC.
- o_pc and o_instruction update together.

IDLE:
- i_load_start → LOAD.
- i_run → RUN.
- i_load_start has priority if both are asserted.

LOAD:
- On entry, load pointer = 0.
- Each i_load_valid cycle: mem[pointer] <= i_load_byte; pointer++; o_load_count++.
- When o_load_count reaches 2^ADDR_WIDTH, further bytes are dropped; pointer does not wrap.
- i_run → RUN. A byte arriving in the same cycle as i_run is still written.
- i_load_start in LOAD restarts the pointer at 0.

RUN, priority per cycle (highest first):
1. i_jump:
   - fetch PC <= {i_jump_address[ADDR_WIDTH-1:2], 2'b00}.
   - o_instruction <= NOP_WORD; o_valid <= 0.
   - Applies even when i_stall = 1.
2. i_stall: PC, o_instruction, o_pc and o_valid are all held.
3. Memory word == HALT_WORD:
   - o_instruction <= HALT_WORD; o_valid <= 1; o_pc <= PC.
   - PC not incremented; state → HALTED.
4. Otherwise:
   - o_instruction <= mem word; o_pc <= PC; o_valid <= 1.
   - PC <= PC + 4, wrapping modulo 2^ADDR_WIDTH.

Also in RUN:
- i_run has no effect.
- i_load_valid is ignored; memory is protected.
- i_load_start is ignored.

HALTED:
- First cycle: the HALT_WORD entry stays in the latch for one cycle, so downstream sees it exactly once.
- Every following clock: o_instruction <= NOP_WORD; o_valid <= 0.
- PC frozen; i_stall and i_jump ignored.
- i_load_start → LOAD with fetch PC <= 0.
- i_run → RUN with fetch PC <= 0 and latch = NOP_WORD, invalid.

Entering RUN from IDLE or LOAD:
- Fetch PC <= 0; latch = NOP_WORD, o_valid 0.
- First real fetch occurs on the next clock, so latency from i_run to the first valid instruction is 2 clocks.

Reset mid-LOAD or mid-RUN: immediate return to the reset state; memory is retained, so i_run alone re-executes the loaded program.

Test Plan:
- Load and run: reset; i_load_start; stream bytes 00 00 00 01, 00 00 00 02, FF FF FF FF (BIG_ENDIAN = 1); i_run → o_load_count = 12; valid words 0x00000001 @pc0, then 0x00000002 @pc4, then 0xFFFFFFFF @pc8; o_halted = 1 next cycle; thereafter o_valid 0, o_pc_next stays 8.
- Stall: i_stall high for 3 cycles while latch holds 0x00000002 → o_instruction, o_pc = 4 and o_pc_next = 8 all unchanged; fetch resumes on the first cycle after release.
- Jump with stall: i_jump = 1, i_stall = 1, i_jump_address = 0x0000_0103 → next cycle o_pc_next = 0x100, o_valid 0, o_instruction = 0; following cycle o_pc = 0x100, o_valid 1.
- Wrap and endianness: BIG_ENDIAN = 0, ADDR_WIDTH = 4; bytes at addresses 14,15,0,1 = 11,22,33,44; jump to 12 → instruction at pc12 fetched, then PC 0x10 wraps to 0; a word read at PC 14 assembles 0x44332211.
- Load overflow and protection: ADDR_WIDTH = 4; send 20 bytes → o_load_count = 16, mem[0] equals the first byte; i_load_valid pulses during RUN → memory unchanged.
- Async reset mid-RUN: drop i_reset_n between clock edges → outputs take reset values immediately; i_run then re-fetches from pc 0 the previously loaded word.
